// File: rtl/program_sequencer.sv
// program_sequencer
//
// Run controller for the 3-bit machine's instruction fetch unit. A program is
// streamed in one word per accepted cycle and kept in a flat program store that
// the fetch unit reads directly. During a run, each instruction is a one-cycle
// FETCH, where halt drops and instr_ptr selects the opcode/operand pair,
// followed by EXEC, which is held until the execute stage reports exec_done.
// The instruction pointer then advances by two or follows a jump. A run ends
// when the next pointer falls off the end of the program, or when a jump
// targets an odd (misaligned) address.
//
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   abort             synchronous return to IDLE from any state
//   load_start        pulse, begin a program load
//   prog_valid/data   streamed program word; prog_ready while loading
//   run_start         pulse, begin execution at ip 0
//   exec_done         execute stage finished the current instruction
//   jump_taken        qualifies exec_done; jump to jump_target
//   program_flat      program store, entry i at [i*WORD_W +: WORD_W]
//   instr_ptr, halt   fetch unit pointer and hold
//   op_valid          fetched opcode/operand valid for execute
//   loaded, done      program resident / run terminated
//   err_misaligned    sticky, run ended on an odd jump target
//   retired           saturating count of completed instructions

module program_sequencer #(
    parameter int PROG_LEN = 16,
    parameter int WORD_W   = 3,
    parameter int CNT_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       abort,
    input  logic                       load_start,
    input  logic                       prog_valid,
    input  logic [WORD_W-1:0]          prog_data,
    output logic                       prog_ready,
    input  logic                       run_start,
    input  logic                       exec_done,
    input  logic                       jump_taken,
    input  logic [3:0]                 jump_target,
    output logic [PROG_LEN*WORD_W-1:0] program_flat,
    output logic [3:0]                 instr_ptr,
    output logic                       halt,
    output logic                       op_valid,
    output logic                       loaded,
    output logic                       done,
    output logic                       err_misaligned,
    output logic [CNT_W-1:0]           retired
);

    // Five bits hold any index 0..PROG_LEN (PROG_LEN is at most 16).
    localparam int IDX_W = 5;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FETCH,
        EXEC,
        DONE
    } state_t;

    state_t                     state;
    state_t                     state_next;

    logic [PROG_LEN*WORD_W-1:0] store;
    logic [IDX_W-1:0]           load_idx;
    logic [3:0]                 ip;
    logic                       loaded_q;
    logic                       err_q;
    logic [CNT_W-1:0]           retired_q;

    logic [4:0]                 seq_ip;
    logic [4:0]                 next_ip;
    logic                       misaligned;
    logic                       past_end;
    logic                       load_last;

    // The sequential advance is formed 5 bits wide so that ip 14 + 2 reads as
    // 16 and terminates the run, rather than wrapping back to 0.
    assign seq_ip     = {1'b0, ip} + 5'd2;
    assign next_ip    = jump_taken ? {1'b0, jump_target} : seq_ip;
    assign misaligned = jump_taken & jump_target[0];
    assign past_end   = (next_ip >= 5'(PROG_LEN));
    assign load_last  = (load_idx == IDX_W'(PROG_LEN - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Abort overrides every transition. load_start takes
    // precedence over run_start wherever both are honoured.
    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (load_start) begin
                        state_next = LOAD;
                    end else if (run_start && loaded_q) begin
                        state_next = FETCH;
                    end
                end
                LOAD: begin
                    if (prog_valid && load_last) begin
                        state_next = IDLE;
                    end
                end
                FETCH: begin
                    state_next = EXEC;
                end
                EXEC: begin
                    if (exec_done) begin
                        if (misaligned || past_end) begin
                            state_next = DONE;
                        end else begin
                            state_next = FETCH;
                        end
                    end
                end
                DONE: begin
                    if (load_start) begin
                        state_next = LOAD;
                    end else if (run_start) begin
                        state_next = FETCH;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Outputs decoded from the state. halt is released only for the single
    // FETCH cycle, so the fetch unit captures exactly one pair per instruction.
    always_comb begin
        halt       = 1'b1;
        op_valid   = 1'b0;
        prog_ready = 1'b0;
        done       = 1'b0;
        case (state)
            LOAD:    prog_ready = 1'b1;
            FETCH:   halt       = 1'b0;
            EXEC:    op_valid   = 1'b1;
            DONE:    done       = 1'b1;
            default: ;
        endcase
    end

    // Datapath registers: program store, load index, instruction pointer,
    // flags and the retired counter. On a terminating exec_done, ip is left
    // at the last valid pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            store     <= '0;
            load_idx  <= '0;
            ip        <= '0;
            loaded_q  <= 1'b0;
            err_q     <= 1'b0;
            retired_q <= '0;
        end else if (abort) begin
            // A load that is cut short leaves an incomplete program behind.
            if (state == LOAD) begin
                loaded_q <= 1'b0;
            end
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (load_start) begin
                        load_idx <= '0;
                        loaded_q <= 1'b0;
                        err_q    <= 1'b0;
                    end else if (run_start && (loaded_q || state == DONE)) begin
                        ip        <= '0;
                        retired_q <= '0;
                        err_q     <= 1'b0;
                    end
                end
                LOAD: begin
                    if (prog_valid) begin
                        for (int i = 0; i < PROG_LEN; i++) begin
                            if (load_idx == IDX_W'(i)) begin
                                store[i*WORD_W +: WORD_W] <= prog_data;
                            end
                        end
                        load_idx <= load_idx + 1'b1;
                        if (load_last) begin
                            loaded_q <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    if (exec_done) begin
                        if (retired_q != '1) begin
                            retired_q <= retired_q + 1'b1;
                        end
                        if (misaligned) begin
                            err_q <= 1'b1;
                        end else if (!past_end) begin
                            ip <= next_ip[3:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign program_flat   = store;
    assign instr_ptr      = ip;
    assign loaded         = loaded_q;
    assign err_misaligned = err_q;
    assign retired        = retired_q;

endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer
//
// Directed bench for program_sequencer. The expected instruction-pointer
// sequence of each run is queued up front. Every FETCH cycle (halt low) pops
// one entry and compares it with instr_ptr. Inputs change and outputs are
// sampled on the falling clock edge.

module tb_program_sequencer;

    localparam int PROG_LEN = 16;
    localparam int WORD_W   = 3;
    localparam int CNT_W    = 16;

    logic                       clk;
    logic                       rst_n;
    logic                       abort;
    logic                       load_start;
    logic                       prog_valid;
    logic [WORD_W-1:0]          prog_data;
    logic                       prog_ready;
    logic                       run_start;
    logic                       exec_done;
    logic                       jump_taken;
    logic [3:0]                 jump_target;
    logic [PROG_LEN*WORD_W-1:0] program_flat;
    logic [3:0]                 instr_ptr;
    logic                       halt;
    logic                       op_valid;
    logic                       loaded;
    logic                       done;
    logic                       err_misaligned;
    logic [CNT_W-1:0]           retired;

    int checks = 0;
    int errors = 0;
    int fetch_cnt = 0;
    int fetch_mark;
    int accepts;
    logic [3:0] exp_q[$];
    logic [PROG_LEN*WORD_W-1:0] img1;
    logic [PROG_LEN*WORD_W-1:0] img2;

    program_sequencer #(
        .PROG_LEN(PROG_LEN),
        .WORD_W  (WORD_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .abort         (abort),
        .load_start    (load_start),
        .prog_valid    (prog_valid),
        .prog_data     (prog_data),
        .prog_ready    (prog_ready),
        .run_start     (run_start),
        .exec_done     (exec_done),
        .jump_taken    (jump_taken),
        .jump_target   (jump_target),
        .program_flat  (program_flat),
        .instr_ptr     (instr_ptr),
        .halt          (halt),
        .op_valid      (op_valid),
        .loaded        (loaded),
        .done          (done),
        .err_misaligned(err_misaligned),
        .retired       (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Called once per falling edge while a run is in flight. A FETCH cycle
    // must have a queued expectation, and instr_ptr must match it.
    task automatic sampleCycle();
        logic [3:0] exp_ip;
        if (!halt) begin
            fetch_cnt++;
            checkOutput("fetch_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                exp_ip = exp_q.pop_front();
                checkOutput("fetch_ip", 64'(instr_ptr), 64'(exp_ip));
            end
        end
    endtask

    task automatic applyStimulus(input logic ld, input logic rs, input logic ab);
        load_start = ld;
        run_start  = rs;
        abort      = ab;
        @(negedge clk);
        load_start = 1'b0;
        run_start  = 1'b0;
        abort      = 1'b0;
    endtask

    task automatic loadProgram(input logic [PROG_LEN*WORD_W-1:0] img, input int n,
                               output int acc);
        acc = 0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            prog_valid = 1'b1;
            prog_data  = img[i*WORD_W +: WORD_W];
            if (prog_ready) acc++;
            @(negedge clk);
        end
        prog_valid = 1'b0;
        prog_data  = '0;
    endtask

    task automatic waitExec();
        int budget;
        budget = 0;
        sampleCycle();
        while (!op_valid && budget < 10) begin
            @(negedge clk);
            sampleCycle();
            budget++;
        end
        checkOutput("exec_reached", 64'(op_valid), 64'd1);
    endtask

    // One instruction: exec_done arrives one cycle after op_valid is seen.
    task automatic runInstr(input logic jmp, input logic [3:0] tgt);
        waitExec();
        @(negedge clk);
        sampleCycle();
        exec_done   = 1'b1;
        jump_taken  = jmp;
        jump_target = tgt;
        @(negedge clk);
        exec_done   = 1'b0;
        jump_taken  = 1'b0;
        jump_target = '0;
    endtask

    task automatic pushLinear(input int last_ip);
        for (int i = 0; i <= last_ip; i += 2) exp_q.push_back(4'(i));
    endtask

    initial begin
        rst_n = 1'b0; abort = 1'b0; load_start = 1'b0; prog_valid = 1'b0;
        prog_data = '0; run_start = 1'b0; exec_done = 1'b0; jump_taken = 1'b0;
        jump_target = '0;
        for (int i = 0; i < PROG_LEN; i++) begin
            img1[i*WORD_W +: WORD_W] = 3'(i % 8);
            img2[i*WORD_W +: WORD_W] = 3'($urandom_range(7, 0));
        end
        repeat (2) @(negedge clk);

        // Reset values.
        checkOutput("rst_halt", 64'(halt), 64'd1);
        checkOutput("rst_op_valid", 64'(op_valid), 64'd0);
        checkOutput("rst_prog_ready", 64'(prog_ready), 64'd0);
        checkOutput("rst_loaded", 64'(loaded), 64'd0);
        checkOutput("rst_flat", 64'(program_flat), 64'd0);
        checkOutput("rst_retired", 64'(retired), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // run_start without a program is ignored.
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (3) begin sampleCycle(); @(negedge clk); end
        checkOutput("noload_halt", 64'(halt), 64'd1);
        checkOutput("noload_op_valid", 64'(op_valid), 64'd0);
        checkOutput("noload_done", 64'(done), 64'd0);

        // Full load with prog_valid held high.
        loadProgram(img1, PROG_LEN, accepts);
        checkOutput("load_accepts", 64'(accepts), 64'(PROG_LEN));
        checkOutput("load_loaded", 64'(loaded), 64'd1);
        checkOutput("load_ready_low", 64'(prog_ready), 64'd0);
        checkOutput("load_entry5", 64'(program_flat[5*WORD_W +: WORD_W]), 64'd5);
        checkOutput("load_entry15", 64'(program_flat[15*WORD_W +: WORD_W]), 64'd7);
        checkOutput("load_flat", 64'(program_flat), 64'(img1));

        // prog_valid outside LOAD leaves the store alone.
        prog_valid = 1'b1; prog_data = 3'd0;
        repeat (2) @(negedge clk);
        prog_valid = 1'b0;
        checkOutput("idle_store_kept", 64'(program_flat), 64'(img1));

        // Sequential run, no jumps.
        pushLinear(14);
        fetch_mark = fetch_cnt;
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (8) runInstr(1'b0, 4'd0);
        checkOutput("seq_fetch_cycles", 64'(fetch_cnt - fetch_mark), 64'd8);
        checkOutput("seq_queue_empty", 64'(exp_q.size()), 64'd0);
        checkOutput("seq_done", 64'(done), 64'd1);
        checkOutput("seq_halt", 64'(halt), 64'd1);
        checkOutput("seq_retired", 64'(retired), 64'd8);
        checkOutput("seq_instr_ptr", 64'(instr_ptr), 64'd14);

        // Jump back to 0 from ip 4, restarted directly from DONE.
        pushLinear(4);
        pushLinear(14);
        applyStimulus(1'b0, 1'b1, 1'b0);
        runInstr(1'b0, 4'd0);
        runInstr(1'b0, 4'd0);
        runInstr(1'b1, 4'd0);
        repeat (8) runInstr(1'b0, 4'd0);
        checkOutput("jmp_queue_empty", 64'(exp_q.size()), 64'd0);
        checkOutput("jmp_done", 64'(done), 64'd1);
        checkOutput("jmp_retired", 64'(retired), 64'd11);

        // Odd jump target terminates with the error flag.
        pushLinear(2);
        applyStimulus(1'b0, 1'b1, 1'b0);
        runInstr(1'b0, 4'd0);
        runInstr(1'b1, 4'd3);
        checkOutput("odd_queue_empty", 64'(exp_q.size()), 64'd0);
        checkOutput("odd_done", 64'(done), 64'd1);
        checkOutput("odd_err", 64'(err_misaligned), 64'd1);
        checkOutput("odd_instr_ptr", 64'(instr_ptr), 64'd2);
        exp_q.push_back(4'd0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitExec();
        checkOutput("rerun_err_clear", 64'(err_misaligned), 64'd0);
        checkOutput("rerun_done_clear", 64'(done), 64'd0);
        checkOutput("rerun_retired_clear", 64'(retired), 64'd0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("abort1_op_valid", 64'(op_valid), 64'd0);

        // Abort mid-EXEC at ip 6, then a clean re-run.
        pushLinear(6);
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (3) runInstr(1'b0, 4'd0);
        waitExec();
        checkOutput("abort_at_ip6", 64'(instr_ptr), 64'd6);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("abort_op_valid", 64'(op_valid), 64'd0);
        checkOutput("abort_halt", 64'(halt), 64'd1);
        checkOutput("abort_loaded", 64'(loaded), 64'd1);
        checkOutput("abort_done", 64'(done), 64'd0);
        pushLinear(14);
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (8) runInstr(1'b0, 4'd0);
        checkOutput("abort_rerun_queue", 64'(exp_q.size()), 64'd0);
        checkOutput("abort_rerun_retired", 64'(retired), 64'd8);
        checkOutput("abort_rerun_done", 64'(done), 64'd1);

        // Reset in the middle of a load, then a full reload.
        loadProgram(img2, 7, accepts);
        checkOutput("partial_accepts", 64'(accepts), 64'd7);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_flat", 64'(program_flat), 64'd0);
        checkOutput("midrst_loaded", 64'(loaded), 64'd0);
        checkOutput("midrst_ready", 64'(prog_ready), 64'd0);
        checkOutput("midrst_halt", 64'(halt), 64'd1);
        checkOutput("midrst_done", 64'(done), 64'd0);
        checkOutput("midrst_err", 64'(err_misaligned), 64'd0);
        checkOutput("midrst_retired", 64'(retired), 64'd0);
        checkOutput("midrst_instr_ptr", 64'(instr_ptr), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        loadProgram(img2, PROG_LEN, accepts);
        checkOutput("reload_accepts", 64'(accepts), 64'(PROG_LEN));
        checkOutput("reload_loaded", 64'(loaded), 64'd1);
        checkOutput("reload_flat", 64'(program_flat), 64'(img2));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
